// File: rtl/fifo_package.sv
// rtl/fifo_package.sv - word format constants, arbiter state type and parity helpers
package fifo_package;

  localparam int DATA_WIDTH  = 9;
  localparam int WIDTH       = DATA_WIDTH - 1;
  localparam     PARITY_BIT  = "MSB";
  localparam     PARITY_TYPE = "EVEN";

  typedef enum logic {ARB_EMPTY, ARB_FULL} arb_state_e;

  function automatic logic [WIDTH-1:0] strip_parity(input logic [DATA_WIDTH-1:0] word);
    if (PARITY_BIT == "MSB") return word[DATA_WIDTH-2:0];
    else                     return word[DATA_WIDTH-1:1];
  endfunction

  function automatic logic parity_ok(input logic [DATA_WIDTH-1:0] word);
    logic             p;
    logic [WIDTH-1:0] d;
    p = (PARITY_BIT == "MSB") ? word[DATA_WIDTH-1] : word[0];
    d = strip_parity(word);
    if (PARITY_TYPE == "EVEN") return p == (^d);
    else                       return p == (~^d);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector searching upward from ptr+1
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [SW-1:0] idx_o,
  output logic          any_o
);

  logic [SW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    // i = N wraps back to ptr itself, so the last winner is considered last
    for (int i = 1; i <= N; i++) begin
      k = SW'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/parity_rr_arbiter.sv
// rtl/parity_rr_arbiter.sv - round-robin FIFO pop arbiter with parity strip/check; PARITY_ERR_CNT_EN enables error counters
module parity_rr_arbiter
  import fifo_package::*;
#(
  parameter  int N_REQ         = 4,
  parameter  int ERR_CNT_WIDTH = 8,
  localparam int SRC_W         = $clog2(N_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]    req_data_i,
  output logic [N_REQ-1:0]               req_grant_o,
  output logic [WIDTH-1:0]               data_o,
  output logic [SRC_W-1:0]               src_o,
  output logic                           parity_err_o,
  output logic                           valid_o,
  input  logic                           grant_i,
  input  logic                           err_clr_i,
  output logic [N_REQ*ERR_CNT_WIDTH-1:0] err_cnt_o
);

  arb_state_e             state_q, state_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic [SRC_W-1:0]       src_q, src_d;
  logic [SRC_W-1:0]       ptr_q, ptr_d;
  logic                   perr_q, perr_d;

  logic [N_REQ-1:0]       pick_gnt;
  logic [SRC_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   load;
  logic                   take;
  logic [DATA_WIDTH-1:0]  win_word;
  logic                   win_perr;

  rr_pick #(.N(N_REQ), .SW(SRC_W)) u_pick (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign load     = (state_q == ARB_EMPTY) || grant_i;
  assign take     = load && pick_any;
  assign win_word = req_data_i[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign win_perr = !parity_ok(win_word);

  // Grants are masked during reset so no FIFO pops into a slot that is being cleared
  assign req_grant_o = (take && rst_n) ? pick_gnt : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    perr_d  = perr_q;
    ptr_d   = ptr_q;
    if (load) begin
      if (pick_any) begin
        state_d = ARB_FULL;
        data_d  = strip_parity(win_word);
        src_d   = pick_idx;
        perr_d  = win_perr;
        ptr_d   = pick_idx;
      end else begin
        state_d = ARB_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      perr_q  <= 1'b0;
      ptr_q   <= SRC_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      perr_q  <= perr_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o      = (state_q == ARB_FULL);
  assign data_o       = data_q;
  assign src_o        = src_q;
  assign parity_err_o = perr_q;

`ifdef PARITY_ERR_CNT_EN
  logic [N_REQ-1:0][ERR_CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (err_clr_i) begin
      cnt_q <= '0;
    end else if (take && win_perr && (cnt_q[pick_idx] != '1)) begin
      cnt_q[pick_idx] <= cnt_q[pick_idx] + 1'b1;
    end
  end

  assign err_cnt_o = cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_parity_rr_arbiter.sv
// tb/tb_parity_rr_arbiter.sv - directed table-driven bench for parity_rr_arbiter
module tb_parity_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid_i;
  logic [35:0] req_data_i;
  logic [3:0]  req_grant_o;
  logic [7:0]  data_o;
  logic [1:0]  src_o;
  logic        parity_err_o;
  logic        valid_o;
  logic        grant_i;
  logic        err_clr_i;
  logic [31:0] err_cnt_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parity_rr_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_grant_o  (req_grant_o),
    .data_o       (data_o),
    .src_o        (src_o),
    .parity_err_o (parity_err_o),
    .valid_o      (valid_o),
    .grant_i      (grant_i),
    .err_clr_i    (err_clr_i),
    .err_cnt_o    (err_cnt_o)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [35:0] data;
    logic        gnt;
    logic        clr;
    logic [3:0]  e_rg;
    logic        e_v;
    logic [7:0]  e_d;
    logic [1:0]  e_s;
    logic        e_p;
    logic [31:0] e_c;
  } vec_t;

  vec_t vec[$];

  function automatic logic [8:0] good(input logic [7:0] d);
    return {^d, d};
  endfunction

  function automatic logic [8:0] bad(input logic [7:0] d);
    return {~^d, d};
  endfunction

  function automatic logic [31:0] cnt(input logic [7:0] c1, input logic [7:0] c3);
`ifdef PARITY_ERR_CNT_EN
    return {c3, 8'h00, c1, 8'h00};
`else
    return 32'h0 & {c3, 8'h00, c1, 8'h00};
`endif
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [35:0] d, input logic g,
                              input logic c, input logic [3:0] rg, input logic ev,
                              input logic [7:0] ed, input logic [1:0] es, input logic ep,
                              input logic [31:0] ec);
    vec_t r;
    r.valid = v; r.data = d; r.gnt = g; r.clr = c;
    r.e_rg = rg; r.e_v = ev; r.e_d = ed; r.e_s = es; r.e_p = ep; r.e_c = ec;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [35:0] fair, bp, one, perr;
    fair = {good(8'h13), good(8'h12), good(8'h11), good(8'h10)};
    bp   = {good(8'h23), good(8'h22), good(8'h21), good(8'h20)};
    one  = {9'h0, 9'h101, 9'h0, 9'h0};
    perr = {9'h0, 9'h0, bad(8'h01), 9'h0};

    // fairness from reset: 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++)
      vec.push_back(mk(4'hF, fair, 1'b1, 1'b0, 4'(1 << (i % 4)), i > 0,
                       (i > 0) ? 8'(8'h10 + (i - 1) % 4) : 8'h00,
                       (i > 0) ? 2'((i - 1) % 4) : 2'd0, 1'b0, cnt(0, 0)));
    vec.push_back(mk(4'h0, fair, 1, 0, 4'b0000, 1, 8'h13, 2'd3, 0, cnt(0, 0)));
    // single word from FIFO 2
    vec.push_back(mk(4'h4, one,  1, 0, 4'b0100, 0, 8'h13, 2'd3, 0, cnt(0, 0)));
    // backpressure: five cycles of grant_i=0
    vec.push_back(mk(4'h0, one,  0, 0, 4'b0000, 1, 8'h01, 2'd2, 0, cnt(0, 0)));
    for (int i = 0; i < 4; i++)
      vec.push_back(mk(4'hF, bp, 0, 0, 4'b0000, 1, 8'h01, 2'd2, 0, cnt(0, 0)));
    vec.push_back(mk(4'hF, bp,   1, 0, 4'b1000, 1, 8'h01, 2'd2, 0, cnt(0, 0)));
    vec.push_back(mk(4'h0, bp,   0, 0, 4'b0000, 1, 8'h23, 2'd3, 0, cnt(0, 0)));
    vec.push_back(mk(4'h0, bp,   1, 0, 4'b0000, 1, 8'h23, 2'd3, 0, cnt(0, 0)));
    // parity errors from FIFO 1
    vec.push_back(mk(4'h2, perr, 1, 0, 4'b0010, 0, 8'h23, 2'd3, 0, cnt(0, 0)));
    vec.push_back(mk(4'h2, perr, 1, 0, 4'b0010, 1, 8'h01, 2'd1, 1, cnt(1, 0)));
    vec.push_back(mk(4'h2, perr, 1, 0, 4'b0010, 1, 8'h01, 2'd1, 1, cnt(2, 0)));
    vec.push_back(mk(4'h0, perr, 1, 0, 4'b0000, 1, 8'h01, 2'd1, 1, cnt(3, 0)));
    // clear collides with a fourth error
    vec.push_back(mk(4'h2, perr, 1, 1, 4'b0010, 0, 8'h01, 2'd1, 1, cnt(3, 0)));
    vec.push_back(mk(4'h0, perr, 1, 0, 4'b0000, 1, 8'h01, 2'd1, 1, cnt(0, 0)));
    vec.push_back(mk(4'h0, perr, 1, 0, 4'b0000, 0, 8'h01, 2'd1, 1, cnt(0, 0)));

    rst_n       = 1'b0;
    req_valid_i = 4'hF;
    req_data_i  = fair;
    grant_i     = 1'b1;
    err_clr_i   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rg",    36'(req_grant_o), 4'b0000);
    chk("rst_valid", 36'(valid_o),     1'b0);
    chk("rst_data",  36'(data_o),      8'h00);
    chk("rst_src",   36'(src_o),       2'd0);
    chk("rst_perr",  36'(parity_err_o), 1'b0);
    chk("rst_cnt",   36'(err_cnt_o),   32'h0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < vec.size(); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      req_valid_i = vec[i].valid;
      req_data_i  = vec[i].data;
      grant_i     = vec[i].gnt;
      err_clr_i   = vec[i].clr;
      @(negedge clk);
      chk($sformatf("v%0d_rg",   i), 64'(req_grant_o),  64'(vec[i].e_rg));
      chk($sformatf("v%0d_val",  i), 64'(valid_o),      64'(vec[i].e_v));
      chk($sformatf("v%0d_data", i), 64'(data_o),       64'(vec[i].e_d));
      chk($sformatf("v%0d_src",  i), 64'(src_o),        64'(vec[i].e_s));
      chk($sformatf("v%0d_perr", i), 64'(parity_err_o), 64'(vec[i].e_p));
      chk($sformatf("v%0d_cnt",  i), 64'(err_cnt_o),    64'(vec[i].e_c));
    end

    // saturation: 260 back-to-back errored loads from FIFO 3
    @(posedge clk); #1;
    req_valid_i = 4'b1000;
    req_data_i  = {bad(8'h03), 27'h0};
    grant_i     = 1'b1;
    err_clr_i   = 1'b0;
    repeat (260) @(posedge clk);
    #1;
    req_valid_i = 4'b0000;
    @(negedge clk);
    chk("sat_cnt",  64'(err_cnt_o),    64'(cnt(8'h00, 8'hFF)));
    chk("sat_val",  64'(valid_o),      64'd1);
    chk("sat_data", 64'(data_o),       64'h03);
    chk("sat_src",  64'(src_o),        64'd3);
    chk("sat_perr", 64'(parity_err_o), 64'd1);

    // reset while the slot is full
    @(posedge clk); #1;
    req_valid_i = 4'b1000;
    grant_i     = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_val", 64'(valid_o), 64'd1);
    rst_n       = 1'b0;
    req_valid_i = 4'hF;
    grant_i     = 1'b1;
    #1;
    chk("mid_rst_rg",  64'(req_grant_o), 64'd0);
    @(negedge clk);
    chk("mid_rst_val",  64'(valid_o),   64'd0);
    chk("mid_rst_data", 64'(data_o),    64'd0);
    chk("mid_rst_src",  64'(src_o),     64'd0);
    chk("mid_rst_cnt",  64'(err_cnt_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rg", 64'(req_grant_o), 64'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
